// File: rtl/counter_ctrl_if.sv
// Control/status bundle between a sequencing master and the counter controller.
// The master drives the command side; the controller returns count and status.
interface counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, pause, abort, auto_reload, start_val, top_val,
        input  value, busy, done, state
    );

    modport slave (
        input  start, pause, abort, auto_reload, start_val, top_val,
        output value, busy, done, state
    );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencing controller for an up-counter: loads a start value, counts to a
// latched terminal value, then stops (one-shot) or reloads (periodic).
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    counter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] top_q;
    logic             reload_q;
    logic             done_q;

    logic             at_top_d;
    logic [WIDTH-1:0] value_inc_d;

    always_comb begin
        at_top_d    = (value_q == top_q);
        value_inc_d = value_q + WIDTH'(1);
    end

    // Priority on every edge: reset > abort > start > per-state behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            value_q  <= '0;
            start_q  <= '0;
            top_q    <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.abort) begin
            state_q <= S_IDLE;
            value_q <= '0;
            done_q  <= 1'b0;
        end else if (bus.start) begin
            start_q  <= bus.start_val;
            top_q    <= bus.top_val;
            reload_q <= bus.auto_reload;
            value_q  <= bus.start_val;
            state_q  <= S_RUN;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    // Pause wins over the terminal check; no increment on the pausing edge.
                    if (bus.pause) begin
                        state_q <= S_HOLD;
                    end else if (at_top_d) begin
                        done_q <= 1'b1;
                        if (reload_q) begin
                            value_q <= start_q;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        value_q <= value_inc_d;
                    end
                end
                S_HOLD: begin
                    if (!bus.pause) begin
                        state_q <= S_RUN;
                    end
                end
                S_IDLE: begin
                end
                S_DONE: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.value = value_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == S_RUN) || (state_q == S_HOLD);
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against an elapsed-count reference model.
module tb_counter_ctrl;
    logic clk;
    logic reset;

    counter_ctrl_if #(.WIDTH(8)) bus ();

    counter_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 counting, 2 paused, 3 finished.
    // The count is tracked as elapsed steps from the latched base.
    int m_mode    = 0;
    int m_base    = 0;
    int m_top     = 0;
    int m_span    = 0;
    int m_elapsed = 0;
    bit m_reload  = 0;
    bit m_done    = 0;

    function automatic int m_value();
        if (m_mode == 0) return 0;
        if (m_mode == 3) return m_top;
        return (m_base + m_elapsed) % 256;
    endfunction

    task automatic model_edge();
        m_done = 0;
        if (reset) begin
            m_mode = 0; m_base = 0; m_top = 0; m_span = 0; m_elapsed = 0; m_reload = 0;
        end else if (bus.abort) begin
            m_mode = 0;
        end else if (bus.start) begin
            m_base    = int'(bus.start_val);
            m_top     = int'(bus.top_val);
            m_reload  = bus.auto_reload;
            m_span    = (m_top - m_base + 256) % 256;
            m_elapsed = 0;
            m_mode    = 1;
        end else if (m_mode == 1) begin
            if (bus.pause) m_mode = 2;
            else if (m_elapsed == m_span) begin
                m_done = 1;
                if (m_reload) m_elapsed = 0;
                else m_mode = 3;
            end else m_elapsed++;
        end else if (m_mode == 2) begin
            if (!bus.pause) m_mode = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string pfx);
        chk({pfx, "_value"}, int'(bus.value), m_value());
        chk({pfx, "_state"}, int'(bus.state), m_mode);
        chk({pfx, "_done"},  int'(bus.done),  int'(m_done));
        chk({pfx, "_busy"},  int'(bus.busy),  (m_mode == 1 || m_mode == 2) ? 1 : 0);
    endtask

    task automatic drive(input bit r, input bit st, input bit pa, input bit ab,
                         input bit ar, input int sv, input int tv);
        reset           = r;
        bus.start       = st;
        bus.pause       = pa;
        bus.abort       = ab;
        bus.auto_reload = ar;
        bus.start_val   = 8'(sv);
        bus.top_val     = 8'(tv);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit rst; bit st; bit pa; bit ab; bit ar; int sv; int tv;
        int exp_value; int exp_state; int exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit st, bit pa, bit ab, bit ar, int sv, int tv,
                                int ev, int es, int ed);
        vec_t v;
        v.rst = rst; v.st = st; v.pa = pa; v.ab = ab; v.ar = ar; v.sv = sv; v.tv = tv;
        v.exp_value = ev; v.exp_state = es; v.exp_done = ed;
        return v;
    endfunction

    initial begin
        int edges;
        int dcount;
        int pcnt;
        bit got;
        bit paused;
        bit st;
        bit pa;
        bit ab;
        bit rs;
        int sv;
        int tv;

        //                rst st pa ab ar  sv   tv  value st done
        vecs.push_back(mk(1, 0, 0, 0, 0,   0,   0,   0, 0, 0)); // reset state
        vecs.push_back(mk(0, 1, 0, 0, 0,   3,   5,   3, 1, 0)); // one-shot 3..5
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   5, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   5, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0,   0,   5, 3, 0)); // pause ignored in DONE
        vecs.push_back(mk(0, 1, 0, 0, 0, 254,   1, 254, 1, 0)); // wrap through 0
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0, 255, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   1, 3, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0,   9,  20,   0, 0, 0)); // abort beats start
        vecs.push_back(mk(0, 1, 0, 0, 0,   9,  20,   9, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   0,   0,   9, 2, 0)); // into HOLD
        vecs.push_back(mk(0, 0, 1, 1, 0,   0,   0,   0, 0, 0)); // abort in HOLD
        vecs.push_back(mk(0, 1, 0, 0, 0,   9,  20,   9, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,  10, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,  40,  50,  40, 1, 0)); // start beats pause
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,  41, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   7,   7,   7, 1, 0)); // start == top
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   7, 3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,   0,   0,   0, 0, 0));

        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].pa, vecs[i].ab, vecs[i].ar,
                  vecs[i].sv, vecs[i].tv);
            step();
            $display("vec %0d: value=%0d state=%0d done=%0d busy=%0d", i,
                     bus.value, bus.state, bus.done, bus.busy);
            chk($sformatf("vec%0d_value", i), int'(bus.value), vecs[i].exp_value);
            chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].exp_state);
            chk($sformatf("vec%0d_done", i),  int'(bus.done),  vecs[i].exp_done);
            chk($sformatf("vec%0d_busy", i),  int'(bus.busy),
                (vecs[i].exp_state == 1 || vecs[i].exp_state == 2) ? 1 : 0);
        end

        // Periodic reload 0..2: two done pulses in six counting edges.
        drive(0, 1, 0, 0, 1, 0, 2);
        step();
        check_model("reload_start");
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            step();
            check_model("reload");
            if (bus.done) dcount++;
        end
        chk("reload_done_count", dcount, 2);
        $display("reload: %0d done pulses, value=%0d", dcount, bus.value);

        // Latency without and with a two-cycle pause at value 6.
        for (int pass = 0; pass < 2; pass++) begin
            drive(0, 1, 0, 0, 0, 0, 10);
            step();
            edges = 0; got = 0; paused = (pass == 0); pcnt = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                if (!paused && bus.value == 8'd6 && bus.state == 2'b01) begin
                    pcnt = 2; paused = 1;
                end
                drive(0, 0, pcnt > 0, 0, 0, 0, 0);
                if (pcnt > 0) pcnt--;
                step();
                edges++;
                check_model("pause_seq");
                if (bus.done) got = 1;
            end
            chk(pass == 0 ? "latency_nopause" : "latency_pause", edges, pass == 0 ? 11 : 14);
            $display("latency pass %0d: %0d edges", pass, edges);
        end

        // Reset in the middle of a run.
        drive(0, 1, 0, 0, 0, 0, 10);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && bus.value != 8'd4; i++) step();
        chk("midrun_reached4", int'(bus.value), 4);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("midrun_rst_value", int'(bus.value), 0);
        chk("midrun_rst_state", int'(bus.state), 0);
        chk("midrun_rst_done",  int'(bus.done),  0);
        chk("midrun_rst_busy",  int'(bus.busy),  0);
        $display("reset mid-run: value=%0d state=%0d", bus.value, bus.state);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 99) < 2);
            ab = ($urandom_range(0, 99) < 5);
            st = ($urandom_range(0, 99) < 12);
            pa = ($urandom_range(0, 99) < 25);
            sv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 255))
                                             : int'($urandom_range(0, 255));
            tv = (sv + int'($urandom_range(0, 6))) % 256;
            drive(rs, st, pa, ab, $urandom_range(0, 1) == 1, sv, tv);
            step();
            check_model("rand");
            $display("rand %0d: r=%0d a=%0d s=%0d p=%0d -> value=%0d state=%0d done=%0d",
                     i, rs, ab, st, pa, bus.value, bus.state, bus.done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
